// File: rtl/hazard_pkg.sv
// Shared definitions for the destination-tracking hazard unit:
// register address width, hardwired-zero index, forward-select
// encodings and the compact stage-entry record carried down the pipe.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  rw;
        logic                  valid;
    } stage_entry_t;

endpackage

// File: rtl/dest_match_cmp.sv
// Combinational comparator: does a tracked stage entry produce the value
// of a given source register? The zero register never matches.
module dest_match_cmp
    import hazard_pkg::*;
(
    input  stage_entry_t          entry,
    input  logic [REG_ADDR_W-1:0] src,
    output logic                  match
);

    // Hit only for a live, writing entry whose destination is a real register.
    always_comb begin
        match = entry.valid & entry.rw & (entry.dest != ZERO_REG) & (entry.dest == src);
    end

endmodule

// File: rtl/dest_hazard_unit.sv
// Destination hazard unit: tracks ID destinations through EX/MEM/WB,
// drives EX operand forwarding selects and the load-use stall.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating 16-bit
// stall_count output.
module dest_hazard_unit
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
`ifdef HAZARD_STALL_CNT_EN
    output logic [15:0]           stall_count,
`endif
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  wb_write
);

    stage_entry_t          ex_entry;
    stage_entry_t          mem_entry;
    stage_entry_t          wb_entry;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_uses_rt;
    logic                  ex_mr;

    logic ex_insert;
    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_a;
    logic wb_hit_a;
    logic mem_hit_b;
    logic wb_hit_b;

    // Load-use detection against the instruction currently in EX.
    dest_match_cmp u_stall_rs (.entry(ex_entry), .src(id_rs), .match(ex_hit_rs));
    dest_match_cmp u_stall_rt (.entry(ex_entry), .src(id_rt), .match(ex_hit_rt));

    // Forwarding sources for the EX operands.
    dest_match_cmp u_fwd_mem_a (.entry(mem_entry), .src(ex_rs), .match(mem_hit_a));
    dest_match_cmp u_fwd_wb_a  (.entry(wb_entry),  .src(ex_rs), .match(wb_hit_a));
    dest_match_cmp u_fwd_mem_b (.entry(mem_entry), .src(ex_rt), .match(mem_hit_b));
    dest_match_cmp u_fwd_wb_b  (.entry(wb_entry),  .src(ex_rt), .match(wb_hit_b));

    // Stall on a load in EX feeding an operand of the ID instruction;
    // a squashed or stalled ID slot enters EX as a bubble.
    always_comb begin
        stall     = id_valid & ex_mr & (ex_hit_rs | (id_uses_rt & ex_hit_rt));
        ex_insert = id_valid & ~stall & ~flush;
    end

    // Advance the shadow pipeline; reset discards every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_entry   <= '0;
            mem_entry  <= '0;
            wb_entry   <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rt <= 1'b0;
            ex_mr      <= 1'b0;
        end else begin
            wb_entry       <= mem_entry;
            mem_entry      <= ex_entry;
            ex_entry.dest  <= id_dest;
            ex_entry.rw    <= id_reg_write & ex_insert;
            ex_entry.valid <= ex_insert;
            ex_mr          <= id_mem_read & ex_insert;
            ex_rs          <= id_rs;
            ex_rt          <= id_rt;
            ex_uses_rt     <= id_uses_rt;
        end
    end

    // Operand source selection; MEM outranks WB as the younger producer.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (ex_entry.valid) begin
            if (mem_hit_a) begin
                fwd_a_sel = FWD_MEM;
            end else if (wb_hit_a) begin
                fwd_a_sel = FWD_WB;
            end
            if (ex_uses_rt) begin
                if (mem_hit_b) begin
                    fwd_b_sel = FWD_MEM;
                end else if (wb_hit_b) begin
                    fwd_b_sel = FWD_WB;
                end
            end
        end
    end

    // Register-file write tracking straight from the WB entry.
    always_comb begin
        wb_dest  = wb_entry.dest;
        wb_write = wb_entry.valid & wb_entry.rw;
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Scoreboard bench for dest_hazard_unit: a queue-based instruction model
// predicts outputs per cycle, a monitor compares on the falling edge.
module tb_dest_hazard_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs, id_rt, id_dest;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, wb_write;
    logic [4:0] wb_dest;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    dest_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall),
`ifdef HAZARD_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .wb_dest(wb_dest), .wb_write(wb_write)
    );

    typedef struct {
        bit valid; bit rw; bit mr; int dest; int rs; int rt; bit uses_rt;
    } instr_t;

    typedef struct {
        logic stall; logic [1:0] fa; logic [1:0] fb; logic [4:0] wbd; logic wbw; logic [15:0] cnt;
    } exp_t;

    instr_t pipe[$];   // [0] in EX, [1] in MEM, [2] in WB
    exp_t   sb[$];
    int     checks = 0;
    int     passed = 0;
    int     model_cnt = 0;
    bit     known = 0;

    function automatic bit produces(instr_t p, int r);
        return p.valid && p.rw && (p.dest != 0) && (p.dest == r);
    endfunction

    function automatic logic [1:0] source_of(int r);
        if (produces(pipe[1], r)) return 2'b10;
        if (produces(pipe[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: outputs are valid every cycle; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", {15'd0, stall}, {15'd0, e.stall});
                chk("fwd_a_sel", {14'd0, fwd_a_sel}, {14'd0, e.fa});
                chk("fwd_b_sel", {14'd0, fwd_b_sel}, {14'd0, e.fb});
                chk("wb_dest", {11'd0, wb_dest}, {11'd0, e.wbd});
                chk("wb_write", {15'd0, wb_write}, {15'd0, e.wbw});
`ifdef HAZARD_STALL_CNT_EN
                chk("stall_count", stall_count, e.cnt);
`endif
            end
        end
    end

    // One clock of stimulus: drive ID, predict, advance the model on the edge.
    task automatic cycle(input bit rst, input bit v, input bit fl, input int rs, input int rt,
                         input bit urt, input int dest, input bit rw, input bit mr, output bit st);
        exp_t   e;
        instr_t n;
        reset = rst; id_valid = v; flush = fl; id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rt = urt; id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr;
        st = 0;
        if (known) begin
            e.stall = v && pipe[0].mr && (produces(pipe[0], rs) || (urt && produces(pipe[0], rt)));
            e.fa  = pipe[0].valid ? source_of(pipe[0].rs) : 2'b00;
            e.fb  = (pipe[0].valid && pipe[0].uses_rt) ? source_of(pipe[0].rt) : 2'b00;
            e.wbd = 5'(pipe[2].dest);
            e.wbw = pipe[2].valid && pipe[2].rw;
            e.cnt = 16'(model_cnt);
            sb.push_back(e);
            st = e.stall;
        end
        @(posedge clk);
        if (rst) begin
            pipe.delete();
            n = '{valid: 0, rw: 0, mr: 0, dest: 0, rs: 0, rt: 0, uses_rt: 0};
            repeat (3) pipe.push_back(n);
            model_cnt = 0;
            known = 1;
        end else if (known) begin
            n.valid = v && !st && !fl;
            n.rw = n.valid && rw; n.mr = n.valid && mr;
            n.dest = dest; n.rs = rs; n.rt = rt; n.uses_rt = urt;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (st && model_cnt < 65535) model_cnt++;
        end
        #1;
    endtask

    // An instruction from the controller's view: held in ID while stalled.
    task automatic issue(input bit fl, input int rs, input int rt, input bit urt,
                         input int dest, input bit rw, input bit mr);
        bit st;
        int guard = 0;
        cycle(0, 1, fl, rs, rt, urt, dest, rw, mr, st);
        while (st && !fl && guard < 4) begin
            guard++;
            cycle(0, 1, fl, rs, rt, urt, dest, rw, mr, st);
        end
    endtask

    task automatic nops(input int k);
        bit st;
        repeat (k) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        bit st;
        // Reset held with a live writer in ID.
        cycle(1, 1, 0, 0, 0, 0, 8, 1, 0, st);
        cycle(1, 1, 0, 0, 0, 0, 8, 1, 0, st);
        issue(0, 0, 0, 0, 8, 1, 0);
        nops(4);
        // Forward distance 0, 1, 2 instructions.
        issue(0, 1, 2, 1, 8, 1, 0); issue(0, 8, 3, 1, 4, 1, 0); nops(3);
        issue(0, 1, 2, 1, 8, 1, 0); nops(1); issue(0, 8, 3, 1, 4, 1, 0); nops(3);
        issue(0, 1, 2, 1, 8, 1, 0); nops(2); issue(0, 8, 3, 1, 4, 1, 0); nops(3);
        // MEM over WB priority, and uses_rt gating.
        issue(0, 1, 2, 1, 9, 1, 0); issue(0, 1, 2, 1, 9, 1, 0); issue(0, 3, 9, 1, 5, 1, 0); nops(3);
        issue(0, 1, 2, 1, 9, 1, 0); issue(0, 1, 2, 1, 9, 1, 0); issue(0, 3, 9, 0, 5, 1, 0); nops(3);
        // Load-use on rs, then rt ignored when unused.
        issue(0, 1, 2, 1, 10, 1, 1); issue(0, 10, 3, 1, 6, 1, 0); nops(3);
        issue(0, 1, 2, 1, 10, 1, 1); issue(0, 3, 10, 0, 6, 1, 0); nops(3);
        // Zero register never forwards nor stalls.
        issue(0, 1, 2, 1, 0, 1, 0); issue(0, 0, 0, 1, 6, 1, 0); nops(2);
        issue(0, 1, 2, 1, 0, 1, 1); issue(0, 0, 0, 1, 6, 1, 0); nops(3);
        // Flushed writer, and flush coinciding with a stall.
        issue(1, 1, 2, 1, 11, 1, 0); issue(0, 11, 11, 1, 6, 1, 0); nops(3);
        issue(0, 1, 2, 1, 15, 1, 1); issue(1, 15, 2, 1, 6, 1, 0); nops(3);
        // Mid-stream reset with three writers in flight.
        issue(0, 1, 2, 1, 12, 1, 0); issue(0, 1, 2, 1, 13, 1, 0); issue(0, 1, 2, 1, 14, 1, 0);
        cycle(1, 1, 0, 12, 13, 1, 7, 1, 0, st);
        issue(0, 12, 13, 1, 7, 1, 0); nops(3);
        // Three load-use events after reset.
        repeat (3) begin
            issue(0, 1, 2, 1, 10, 1, 1); issue(0, 3, 10, 1, 6, 1, 0);
        end
        nops(3);
        // Randomized traffic over a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, st);
            end else if ($urandom_range(0, 5) == 0) begin
                nops(1);
            end else begin
                issue(($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) == 0));
            end
        end
        nops(1);
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
